ll_free_ctrl: RTL
=================

LL_FREE_CTRL -- requirements
Module: ll_free_ctrl

Interface
REQ-001 Parameter N, default ll_pkg::N (256), number of linked-list nodes; SHALL be a power of two, at least 4.
REQ-002 Parameter W_PTR, default $clog2(N), pointer width; Pointer type SHALL be logic [W_PTR-1:0].
REQ-003 clk  in  1  single clock; all logic SHALL be rising-edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 alloc_req  in  2  per-requester allocate request (valid), level.
REQ-006 alloc_gnt  out  2  one-hot grant (ready), combinational from registered state and alloc_req.
REQ-007 alloc_ptr  out  W_PTR  allocated node; SHALL equal head and be valid while any alloc_gnt bit is high.
REQ-008 free_vld  in  1  return one node this cycle.
REQ-009 free_ptr  in  W_PTR  node being returned.
REQ-010 free_cnt  out  W_PTR+1  number of free nodes, registered, range 0..N.
REQ-011 ready  out  1  initialisation complete; registered.
REQ-012 err  out  1  one-cycle pulse on a detected illegal free (REQ-031).

Function
REQ-013 State machine SHALL have states INIT and RUN only.
REQ-014 INIT SHALL write next[i]=i+1 for i=0..N-1, one entry per cycle, with i counting 0..N-1.
REQ-015 At the end of INIT, head=0, tail=N-1, free_cnt=N, state=RUN, and ready=1; INIT SHALL last exactly N cycles after rst falls.
REQ-016 In INIT, alloc_gnt SHALL be 0 and free_vld SHALL be ignored.
REQ-017 In RUN with free_cnt>0, exactly one requesting bit SHALL be granted per cycle.
REQ-018 Round-robin: with both bits requesting, the bit not granted last time SHALL win; a single requester SHALL win immediately; last-grant SHALL reset to 1, so requester 0 wins the first tie.
REQ-019 A grant SHALL complete the transfer in that cycle; next cycle head=next[head] and free_cnt-1.
REQ-020 free_cnt=0 SHALL force alloc_gnt=0, with no stall beyond that.
REQ-021 A free SHALL write next[tail]=free_ptr and set tail=free_ptr, then free_cnt+1.
REQ-022 Free with free_cnt=0 SHALL set head=tail=free_ptr, and no RAM link write is needed.
REQ-023 Simultaneous alloc and free SHALL leave free_cnt unchanged.
REQ-024 Simultaneous alloc and free with free_cnt=1 SHALL set head=tail=free_ptr (bypass).
REQ-025 Simultaneous alloc and free with free_cnt=0 SHALL perform no grant and apply the free only.
REQ-026 free_cnt SHALL never exceed N; a free at free_cnt=N SHALL be dropped.

Reset
REQ-027 While rst=1: alloc_gnt=0, ready=0, err=0, free_cnt=0, head=0, tail=0, state=INIT, INIT counter=0.
REQ-028 Assertion of rst in RUN SHALL discard all list state and rerun INIT in full.
REQ-029 next[] contents SHALL need no reset; INIT rewrites them.

Configuration
REQ-030 Macro LL_FREE_CHECK_EN SHALL compile in an N-bit allocated bitmap: set on grant, cleared on free, all 0 after INIT.
REQ-031 With LL_FREE_CHECK_EN, a free of a node whose bit is 0 SHALL be dropped and SHALL pulse err for one cycle.
REQ-032 Without LL_FREE_CHECK_EN: no bitmap, err tied 0, every free in RUN accepted.

Structure
REQ-033 Package ll_pkg SHALL hold N, W_PTR, and typedef Pointer, shared with req_gen and the test bench.
REQ-034 Sub-module ll_next_ram SHALL hold next[0..N-1] with one write port and asynchronous read at head.
REQ-035 Arbiter, FSM, head/tail/count and check logic SHALL reside in ll_free_ctrl.

Verification
REQ-036 Init: rst 2 cycles, then low -> ready=0 for 256 cycles, then ready=1 and free_cnt=256.
REQ-037 Drain: alloc_req=01 continuously -> alloc_ptr 0,1,2..255 on consecutive cycles; gnt=0 once free_cnt=0.
REQ-038 Fairness: alloc_req=11 for 6 cycles -> alloc_gnt 01,10,01,10,01,10; ptrs 0..5; free_cnt=250.
REQ-039 Bypass: drain to free_cnt=1, then alloc and free(7) in the same cycle -> free_cnt stays 1, next grant returns 7.
REQ-040 Reuse: free 5 then 9 while the list is empty -> next grants return 5 then 9.
REQ-041 Error/reset (LL_FREE_CHECK_EN): free(3) never allocated -> err pulses once and free_cnt is unchanged; rst mid-RUN -> ready=0 and INIT restarts.

Source files
------------

// File: rtl/ll_pkg.sv
// Shared constants and types for the linked-list free-node controller.
package ll_pkg;

   localparam int N     = 256;
   localparam int W_PTR = $clog2(N);

   typedef logic [W_PTR-1:0] Pointer;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/ll_next_ram.sv
// Link storage next[0..N-1]: one synchronous write port, asynchronous read.
// Contents are never reset; the controller rewrites every entry after reset.
module ll_next_ram #(
   parameter int N     = ll_pkg::N,
   parameter int W_PTR = $clog2(N)
) (
   input  logic             clk,
   input  logic             i_we,
   input  logic [W_PTR-1:0] i_waddr,
   input  logic [W_PTR-1:0] i_wdata,
   input  logic [W_PTR-1:0] i_raddr,
   output logic [W_PTR-1:0] o_rdata
);

   logic [W_PTR-1:0] r_next [N];

   // single write port, used by the init sweep and by list appends
   always_ff @(posedge clk) begin
      if (i_we) r_next[i_waddr] <= i_wdata;
   end

   assign o_rdata = r_next[i_raddr];

endmodule

// File: rtl/ll_free_ctrl.sv
// Free-node list controller: hands out nodes to two round-robin requesters
// and takes returned nodes back onto the tail of the list.
// Optional macro LL_FREE_CHECK_EN adds an allocated-node bitmap that drops
// frees of nodes not currently allocated and pulses err for each one.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_INIT | sweeping next[i]=i+1, one entry per cycle; no grants/frees
//   ST_RUN  | list live: grants pop head, frees append at tail
module ll_free_ctrl #(
   parameter int N     = ll_pkg::N,
   parameter int W_PTR = $clog2(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       alloc_req,
   output logic [1:0]       alloc_gnt,
   output logic [W_PTR-1:0] alloc_ptr,
   input  logic             free_vld,
   input  logic [W_PTR-1:0] free_ptr,
   output logic [W_PTR:0]   free_cnt,
   output logic             ready,
   output logic             err
);

   import ll_pkg::*;

   localparam logic [W_PTR:0]   CNT_FULL = (W_PTR+1)'(N);
   localparam logic [W_PTR:0]   CNT_ONE  = (W_PTR+1)'(1);
   localparam logic [W_PTR-1:0] PTR_LAST = W_PTR'(N-1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [W_PTR-1:0] r_init_cnt;
   logic [W_PTR-1:0] r_head;
   logic [W_PTR-1:0] r_tail;
   logic [W_PTR:0]   r_cnt;
   logic             r_ready;
   logic             r_err;
   logic             r_last_gnt;

   logic [W_PTR-1:0] w_next_head;
   logic             w_ram_we;
   logic [W_PTR-1:0] w_ram_waddr;
   logic [W_PTR-1:0] w_ram_wdata;
   logic             w_run;
   logic             w_init_last;
   logic             w_cnt_zero;
   logic             w_cnt_one;
   logic             w_cnt_full;
   logic             w_alloc;
   logic             w_free_ok;
   logic             w_free_acc;
   logic             w_bad_free;

   assign w_run       = (r_state == ST_RUN);
   assign w_init_last = (r_init_cnt == PTR_LAST);
   assign w_cnt_zero  = (r_cnt == '0);
   assign w_cnt_one   = (r_cnt == CNT_ONE);
   assign w_cnt_full  = (r_cnt == CNT_FULL);
   assign w_alloc     = |alloc_gnt;
   assign w_free_acc  = w_run && free_vld && !w_cnt_full && w_free_ok;

`ifdef LL_FREE_CHECK_EN
   logic [N-1:0] r_bitmap;

   // track which nodes are held by requesters; a node leaves on grant, returns on free
   always_ff @(posedge clk) begin
      if (rst) begin
         r_bitmap <= '0;
      end else if (w_run) begin
         if (w_alloc)    r_bitmap[r_head]   <= 1'b1;
         if (w_free_acc) r_bitmap[free_ptr] <= 1'b0;
      end
   end

   assign w_free_ok  = r_bitmap[free_ptr];
   assign w_bad_free = w_run && free_vld && !r_bitmap[free_ptr];
`else
   assign w_free_ok  = 1'b1;
   assign w_bad_free = 1'b0;
`endif

   // state register
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_INIT;
      else     r_state <= w_state_nxt;
   end

   // next state: leave INIT after the last link entry is written
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_INIT: if (w_init_last) w_state_nxt = ST_RUN;
         ST_RUN:  w_state_nxt = ST_RUN;
         default: w_state_nxt = ST_INIT;
      endcase
   end

   // outputs: round-robin grant and link-RAM write port
   always_comb begin
      alloc_gnt   = 2'b00;
      w_ram_we    = 1'b0;
      w_ram_waddr = r_tail;
      w_ram_wdata = free_ptr;
      case (r_state)
         ST_INIT: begin
            w_ram_we    = 1'b1;
            w_ram_waddr = r_init_cnt;
            w_ram_wdata = r_init_cnt + 1'b1;
         end
         ST_RUN: begin
            if (!w_cnt_zero) begin
               case (alloc_req)
                  2'b01:   alloc_gnt = 2'b01;
                  2'b10:   alloc_gnt = 2'b10;
                  2'b11:   alloc_gnt = r_last_gnt ? 2'b01 : 2'b10;
                  default: alloc_gnt = 2'b00;
               endcase
            end
            // an empty list has no tail link to patch; the freed node becomes head
            w_ram_we = w_free_acc && !w_cnt_zero;
         end
         default: ;
      endcase
   end

   // head/tail/count bookkeeping, init sweep counter and error pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         r_init_cnt <= '0;
         r_head     <= '0;
         r_tail     <= '0;
         r_cnt      <= '0;
         r_ready    <= 1'b0;
         r_err      <= 1'b0;
         r_last_gnt <= 1'b1;
      end else begin
         r_err <= w_bad_free;
         if (!w_run) begin
            r_init_cnt <= r_init_cnt + 1'b1;
            if (w_init_last) begin
               r_head  <= '0;
               r_tail  <= PTR_LAST;
               r_cnt   <= CNT_FULL;
               r_ready <= 1'b1;
            end
         end else begin
            if (w_alloc) r_last_gnt <= alloc_gnt[1];
            case ({w_alloc, w_free_acc})
               2'b10: begin
                  r_head <= w_next_head;
                  r_cnt  <= r_cnt - 1'b1;
               end
               2'b01: begin
                  r_tail <= free_ptr;
                  if (w_cnt_zero) r_head <= free_ptr;
                  r_cnt  <= r_cnt + 1'b1;
               end
               2'b11: begin
                  // popping the only node while appending: freed node is the whole list
                  r_tail <= free_ptr;
                  if (w_cnt_one) r_head <= free_ptr;
                  else           r_head <= w_next_head;
               end
               default: ;
            endcase
         end
      end
   end

   ll_next_ram #(
      .N     (N),
      .W_PTR (W_PTR)
   ) u_next_ram (
      .clk     (clk),
      .i_we    (w_ram_we),
      .i_waddr (w_ram_waddr),
      .i_wdata (w_ram_wdata),
      .i_raddr (r_head),
      .o_rdata (w_next_head)
   );

   assign alloc_ptr = r_head;
   assign free_cnt  = r_cnt;
   assign ready     = r_ready;
   assign err       = r_err;

endmodule
